// File: rtl/ddr_pi_code_ramp.sv
// Drives the packed PI config word, slewing the code one LSB per step toward a requested target.
// Defining DDR_PI_RAMP_JUMP_EN adds i_jump, which loads the target in a single step.

module ddr_pi_code_ramp #(
    parameter int         PWIDTH     = 15,
    parameter int         SETTLE_W   = 4,
    parameter logic [5:0] RESET_CODE = 6'd0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [5:0]          i_target_code,
    input  logic [3:0]          i_xcpl,
    input  logic [3:0]          i_gear,
    input  logic                i_ena,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
`ifdef DDR_PI_RAMP_JUMP_EN
    input  logic                i_jump,
`endif
    output logic [PWIDTH-1:0]   o_pi_cfg,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;
    localparam int         CFG_W     = 15;

    typedef struct packed {
        logic [5:0]          target;
        logic [SETTLE_W-1:0] settle;
        logic                up;
    } req_t;

    logic [1:0]          state;
    logic [5:0]          code_q;
    logic [3:0]          xcpl_q;
    logic [3:0]          gear_q;
    logic                ena_q;
    req_t                req_q;
    logic [SETTLE_W-1:0] cnt_q;
    logic                last_q;
`ifdef DDR_PI_RAMP_JUMP_EN
    logic                jump_q;
`endif

    logic [5:0]          diff;
    logic [5:0]          step_code;
    logic [CFG_W-1:0]    cfg;

    // Direction is fixed at accept; modulo-64 distance of 32 resolves upward.
    always_comb begin
        diff      = i_target_code - code_q;
        step_code = req_q.up ? code_q + 6'd1 : code_q - 6'd1;
`ifdef DDR_PI_RAMP_JUMP_EN
        if (jump_q) step_code = req_q.target;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            code_q <= RESET_CODE;
            xcpl_q <= '0;
            gear_q <= '0;
            ena_q  <= 1'b0;
            req_q  <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
`ifdef DDR_PI_RAMP_JUMP_EN
            jump_q <= 1'b0;
`endif
        end else begin
            ena_q <= i_ena;
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_q.target <= i_target_code;
                        req_q.settle <= i_settle_cycles;
                        req_q.up     <= (diff <= 6'd32);
                        xcpl_q       <= i_xcpl;
                        gear_q       <= i_gear;
                        last_q       <= 1'b0;
`ifdef DDR_PI_RAMP_JUMP_EN
                        jump_q       <= i_jump;
`endif
                        state        <= (diff == 6'd0) ? ST_DONE : ST_STEP;
                    end
                end
                ST_STEP: begin
                    code_q <= step_code;
                    last_q <= (step_code == req_q.target);
                    cnt_q  <= req_q.settle;
                    state  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) state <= last_q ? ST_DONE : ST_STEP;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cfg         = {ena_q, gear_q, xcpl_q, code_q};
    assign o_pi_cfg    = PWIDTH'(cfg);
    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state == ST_STEP) || (state == ST_SETTLE);
    assign o_done      = (state == ST_DONE);

endmodule

// File: doc/ddr_pi_code_ramp.md
Name: ddr_pi_code_ramp

Overview:
- Sequential driver of the packed phase-interpolator config word consumed by the PI wrapper/decoder.
- Accepts a target phase code through a valid/ready handshake and slews the live code one LSB per step along the shortest circular path, with a programmable settle interval after each step. This keeps interpolator moves glitch-free.
- Sits in the per-lane DDR PI control path between CSR/training logic and the analog PI.
- Quadrant wrap (63 <-> 0) is handled natively.

Parameters:
- PWIDTH, 15, width of o_pi_cfg; fixed layout: [5:0] binary code ({quad[1:0], fine[3:0]}), [9:6] xcpl, [13:10] gear, [14] ena.
- SETTLE_W, 4, width of settle-count input.
- RESET_CODE, 0, code value loaded at reset (6 bits).

Ports:
- i_clk  in  1  block clock.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  new target request.
- o_req_ready  out  1  high only in IDLE.
- i_target_code  in  6  requested binary PI code.
- i_xcpl  in  4  cross-couple trim; sampled at accept.
- i_gear  in  4  gear setting; sampled at accept.
- i_ena  in  1  PI enable; registered every cycle.
- i_settle_cycles  in  SETTLE_W  idle cycles after each step (0 allowed).
- o_pi_cfg  out  PWIDTH  packed config to PI wrapper.
- o_busy  out  1  high in STEP/SETTLE.
- o_done  out  1  one-cycle pulse when the target is reached.

Behaviour:
- Reset:
  - code=RESET_CODE; xcpl=0; gear=0; ena=0; state=IDLE.
  - o_req_ready=1, o_busy=0, o_done=0. All registers are cleared synchronously.
- o_pi_cfg is fully registered. No combinational path from inputs to outputs.
- ena field follows i_ena with 1-cycle latency, independent of FSM state.
- Accept occurs when i_req_valid && o_req_ready:
  - latch target, xcpl, gear, settle count;
  - compute diff = (target - code) mod 64 (6-bit wrap);
  - direction = up if diff in 1..32, down if diff in 33..63 (tie at 32 steps up);
  - next state = STEP, or DONE if diff==0.
- xcpl/gear fields update in o_pi_cfg on the cycle after accept.
- STEP (1 cycle): code <= code±1 mod 64, so 63+1=0 and 0-1=63.
  - If the new code equals target -> SETTLE with last flag set.
  - Otherwise -> SETTLE.
- SETTLE: counter loads i_settle_cycles value latched at accept and counts down.
  - At 0: last flag -> DONE, else -> STEP.
  - settle=0 means STEP->SETTLE->STEP, i.e. one code change per 2 cycles.
- DONE (1 cycle): o_done=1, then -> IDLE. o_req_ready returns high the cycle after o_done.
- Latency for N steps with settle S: accept-to-o_done = N*(S+2)+1 cycles. N=0 gives o_done 1 cycle after accept.
- Code changes by at most 1 LSB per cycle at o_pi_cfg[5:0], including across quadrant boundaries.
- Requests are held off while busy: ready=0, and i_req_valid is ignored with no queuing.
- i_rst mid-ramp: return to reset values on the next edge. No o_done is issued.
- i_ena low does not stop the FSM; the ramp continues with ena=0.

Optional Feature:
- Macro: DDR_PI_RAMP_JUMP_EN.
- Defined:
  - adds input port i_jump (1 bit), sampled at accept;
  - if i_jump=1, code loads the target directly on the STEP cycle, then one settle interval, then DONE, regardless of distance.
- Undefined:
  - port is absent; every request ramps single-LSB.

Test Plan:
- Reset, then idle -> o_pi_cfg=15'h0000, o_req_ready=1, o_busy=0, o_done=0.
- From code 10, request 14 with settle=2 -> codes 11,12,13,14, each held 3 cycles after its step cycle; o_done at accept+17; xcpl/gear visible at accept+1.
- From code 62, request 1 with settle=0 -> sequence 63,0,1 (up, across wrap); o_done at accept+7.
- From code 5, request 37 (diff=32, tie) -> steps up through 32 codes. From 5, request 60 -> steps down 5,4,...,0,63,...,60.
- Request target == current code -> no code change; o_done 1 cycle after accept. Pulse i_req_valid while busy -> ignored, final code unchanged.
- Assert i_rst mid-ramp at code 20 -> next cycle code=RESET_CODE, IDLE, no o_done. With DDR_PI_RAMP_JUMP_EN, i_jump=1 from 0 to 40 with settle=3 -> single jump to 40, o_done at accept+6.
